// File: rtl/gnrc_delay_line_if.sv
// Signal bundle for gnrc_delay_line: stage control, payload in/out and depth/occupancy status.
// The master modport drives the line, the slave modport is the delay line itself.
interface gnrc_delay_line_if #(
  parameter int  MAX_DEPTH = 8,
  parameter type DTYPE     = logic
);
  localparam int DW = $clog2(MAX_DEPTH + 1);

  logic          flush_i;
  logic          en_i;
  logic          valid_i;
  DTYPE          d_i;
  logic [DW-1:0] depth_i;
  logic          valid_o;
  DTYPE          d_o;
  logic [DW-1:0] depth_o;
  logic [DW-1:0] cnt_o;
  logic          busy_o;
  logic          depth_err_o;

  modport master (
    output flush_i, en_i, valid_i, d_i, depth_i,
    input  valid_o, d_o, depth_o, cnt_o, busy_o, depth_err_o
  );

  modport slave (
    input  flush_i, en_i, valid_i, d_i, depth_i,
    output valid_o, d_o, depth_o, cnt_o, busy_o, depth_err_o
  );
endinterface

// File: rtl/gnrc_delay_line.sv
// Valid-tagged delay line with stall, flush and a runtime delay of 0..MAX_DEPTH stages.
// Build macro GNRC_DELAY_LINE_ZERO_INVALID_EN zeroes the payload of invalid entries.
module gnrc_delay_line #(
  parameter int  MAX_DEPTH = 8,
  parameter int  RST_DEPTH = MAX_DEPTH,
  parameter type DTYPE     = logic
) (
  input logic              clk_i,
  input logic              rst_ni,
  gnrc_delay_line_if.slave dl
);
  localparam int DW = $clog2(MAX_DEPTH + 1);

  DTYPE                 r_data [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] r_vld;
  logic [DW-1:0]        r_depth;
  logic                 r_depth_err;

  logic [DW-1:0] w_cnt;
  logic [DW-1:0] w_depth_next;
  logic          w_depth_ovf;
  logic          w_depth_upd;
  logic          w_vld_sel;
  logic          w_valid;
  DTYPE          w_d0;
  DTYPE          w_d_sel;
  DTYPE          w_d;

  // Occupancy of the active window and the depth-change qualifier.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      w_cnt = w_cnt + ((r_vld[i] && (DW'(i) < r_depth)) ? DW'(1) : DW'(0));
    end
    w_depth_ovf  = (dl.depth_i > DW'(MAX_DEPTH));
    w_depth_next = w_depth_ovf ? DW'(MAX_DEPTH) : dl.depth_i;
    // A new delay is only safe when nothing is in flight and nothing enters this edge.
    w_depth_upd  = ((w_cnt == '0) && !(dl.en_i && dl.valid_i)) || dl.flush_i;
  end

  // Stage-0 payload and output tap at the end of the active window.
  always_comb begin
`ifdef GNRC_DELAY_LINE_ZERO_INVALID_EN
    w_d0 = dl.valid_i ? dl.d_i : '0;
`else
    w_d0 = dl.d_i;
`endif
    w_vld_sel = 1'b0;
    w_d_sel   = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      w_vld_sel = (r_depth == DW'(i + 1)) ? r_vld[i]  : w_vld_sel;
      w_d_sel   = (r_depth == DW'(i + 1)) ? r_data[i] : w_d_sel;
    end
    if (r_depth == '0) begin
      w_valid = dl.valid_i;
      w_d     = dl.d_i;
    end else begin
      w_valid = w_vld_sel;
      w_d     = w_d_sel;
    end
  end

  assign dl.valid_o     = w_valid;
`ifdef GNRC_DELAY_LINE_ZERO_INVALID_EN
  assign dl.d_o         = w_valid ? w_d : '0;
`else
  assign dl.d_o         = w_d;
`endif
  assign dl.depth_o     = r_depth;
  assign dl.cnt_o       = w_cnt;
  assign dl.busy_o      = (w_cnt != '0);
  assign dl.depth_err_o = r_depth_err;

  // Stage array: flush clears, enable shifts; stages past the window always load invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        r_data[i] <= '0;
      end
      r_vld <= '0;
    end else if (dl.flush_i) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        r_data[i] <= '0;
      end
      r_vld <= '0;
    end else if (dl.en_i) begin
      r_data[0] <= w_d0;
      r_vld[0]  <= dl.valid_i && (r_depth != '0);
      for (int i = 1; i < MAX_DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1] && (DW'(i) < r_depth);
      end
    end
  end

  // Applied delay and the out-of-range request pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_depth     <= DW'(RST_DEPTH);
      r_depth_err <= 1'b0;
    end else begin
      if (w_depth_upd) begin
        r_depth <= w_depth_next;
      end
      r_depth_err <= w_depth_upd && w_depth_ovf;
    end
  end
endmodule

// File: tb/tb_gnrc_delay_line.sv
// Self-checking bench for gnrc_delay_line: directed scenarios plus randomized traffic
// checked against an entry-age reference model.
module tb_gnrc_delay_line;
  localparam int MAX_DEPTH = 8;
  localparam int RST_DEPTH = 4;
  localparam int DW        = $clog2(MAX_DEPTH + 1);

  typedef logic [7:0] data_t;
  typedef struct {
    int    age;
    data_t d;
  } ent_t;

  logic clk;
  logic rst_n;

  gnrc_delay_line_if #(.MAX_DEPTH(MAX_DEPTH), .DTYPE(data_t)) dl ();

  gnrc_delay_line #(
    .MAX_DEPTH(MAX_DEPTH),
    .RST_DEPTH(RST_DEPTH),
    .DTYPE    (data_t)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .dl    (dl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each in-flight entry carries the number of enabled edges since it was accepted.
  ent_t            q[$];
  int              m_depth;
  bit              m_err;
  bit              e_valid;
  bit              e_dchk;
  data_t           e_d;
  int              e_cnt;
  logic [2*DW+2:0] e_vec;
  int              checks = 0;
  int              errors = 0;

  wire [2*DW+2:0] w_obs = {dl.valid_o, dl.cnt_o, dl.busy_o, dl.depth_o, dl.depth_err_o};

  function automatic void model_eval();
    e_cnt = q.size();
    if (m_depth == 0) begin
      e_valid = dl.valid_i;
      e_d     = dl.d_i;
    end else if (q.size() > 0 && q[0].age == m_depth) begin
      e_valid = 1'b1;
      e_d     = q[0].d;
    end else begin
      e_valid = 1'b0;
      e_d     = 8'h00;
    end
`ifdef GNRC_DELAY_LINE_ZERO_INVALID_EN
    if (!e_valid) e_d = 8'h00;
    e_dchk = 1'b1;
`else
    e_dchk = e_valid;
`endif
    e_vec = {e_valid, DW'(e_cnt), (e_cnt != 0), DW'(m_depth), m_err};
  endfunction

  function automatic void model_edge();
    bit upd;
    upd = (q.size() == 0 && !(dl.en_i && dl.valid_i)) || dl.flush_i;
    if (dl.flush_i) begin
      q.delete();
    end else if (dl.en_i) begin
      for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
      while (q.size() > 0 && q[0].age > m_depth) void'(q.pop_front());
      if (dl.valid_i && m_depth > 0) q.push_back('{1, dl.d_i});
    end
    m_err = upd && (int'(dl.depth_i) > MAX_DEPTH);
    if (upd) m_depth = (int'(dl.depth_i) > MAX_DEPTH) ? MAX_DEPTH : int'(dl.depth_i);
  endfunction

  task automatic set_in(input bit f, input bit e, input bit v, input data_t d, input int dep);
    dl.flush_i = f;
    dl.en_i    = e;
    dl.valid_i = v;
    dl.d_i     = d;
    dl.depth_i = DW'(dep);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input int dep);
    for (int k = 0; k < n; k++) begin
      set_in(1'b0, 1'b1, 1'b0, 8'h00, dep);
      tick();
    end
  endtask

  task automatic test_reset();
    set_in(1'b0, 1'b0, 1'b0, 8'h00, RST_DEPTH);
    rst_n = 1'b0;
    #13;
    checks++;
    if (w_obs !== {1'b0, DW'(0), 1'b0, DW'(RST_DEPTH), 1'b0}) begin
      errors++;
      $display("FAIL reset status got %b exp %b", w_obs, {1'b0, DW'(0), 1'b0, DW'(RST_DEPTH), 1'b0});
    end
    checks++;
    if (dl.d_o !== 8'h00) begin
      errors++;
      $display("FAIL reset d_o got %h exp 00", dl.d_o);
    end
    q.delete();
    m_depth = RST_DEPTH;
    m_err   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    data_t din[3] = '{8'h11, 8'h22, 8'h33};
    data_t seen[$];
    int    peak = 0;
    for (int k = 0; k < 10; k++) begin
      set_in(1'b0, 1'b1, k < 3, din[k % 3], 4);
      @(negedge clk);
      model_eval();
      checks++;
      if (w_obs !== e_vec) begin
        errors++;
        $display("FAIL basic status k=%0d got %b exp %b", k, w_obs, e_vec);
      end
      if (e_dchk) begin
        checks++;
        if (dl.d_o !== e_d) begin
          errors++;
          $display("FAIL basic data k=%0d got %h exp %h", k, dl.d_o, e_d);
        end
      end
      if (dl.valid_o) seen.push_back(dl.d_o);
      if (int'(dl.cnt_o) > peak) peak = int'(dl.cnt_o);
      tick();
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 8'h11 || seen[1] !== 8'h22 || seen[2] !== 8'h33) begin
      errors++;
      $display("FAIL basic order got %0d entries exp 11 22 33", seen.size());
    end
    checks++;
    if (peak != 3) begin
      errors++;
      $display("FAIL basic cnt_peak got %0d exp 3", peak);
    end
  endtask

  task automatic test_stall();
    int first = -1;
    idle(2, 3);
    for (int k = 0; k < 14; k++) begin
      set_in(1'b0, !(k >= 2 && k < 7), k == 0, 8'hA0, 3);
      @(negedge clk);
      model_eval();
      checks++;
      if (w_obs !== e_vec) begin
        errors++;
        $display("FAIL stall status k=%0d got %b exp %b", k, w_obs, e_vec);
      end
      if (e_dchk) begin
        checks++;
        if (dl.d_o !== e_d) begin
          errors++;
          $display("FAIL stall data k=%0d got %h exp %h", k, dl.d_o, e_d);
        end
      end
      if (k >= 2 && k <= 7) begin
        checks++;
        if (dl.cnt_o !== DW'(1)) begin
          errors++;
          $display("FAIL stall cnt k=%0d got %0d exp 1", k, dl.cnt_o);
        end
      end
      if (dl.valid_o && dl.d_o === 8'hA0 && first < 0) first = k;
      tick();
    end
    checks++;
    if (first != 3 + 5) begin
      errors++;
      $display("FAIL stall latency got %0d exp %0d", first, 3 + 5);
    end
  endtask

  task automatic test_depth_change();
    int exits[$];
    idle(2, 4);
    for (int k = 0; k < 12; k++) begin
      set_in(1'b0, 1'b1, k < 2, data_t'($urandom), (k < 2) ? 4 : 1);
      @(negedge clk);
      model_eval();
      checks++;
      if (w_obs !== e_vec) begin
        errors++;
        $display("FAIL depchg status k=%0d got %b exp %b", k, w_obs, e_vec);
      end
      if (e_dchk) begin
        checks++;
        if (dl.d_o !== e_d) begin
          errors++;
          $display("FAIL depchg data k=%0d got %h exp %h", k, dl.d_o, e_d);
        end
      end
      if (dl.valid_o) exits.push_back(k);
      tick();
    end
    checks++;
    if (exits.size() != 2 || exits[0] != 4 || exits[1] != 5) begin
      errors++;
      $display("FAIL depchg exits got %0d entries exp cycles 4 5", exits.size());
    end
    checks++;
    if (dl.depth_o !== DW'(1)) begin
      errors++;
      $display("FAIL depchg final_depth got %0d exp 1", dl.depth_o);
    end
  endtask

  task automatic test_passthrough();
    int pulses = 0;
    idle(3, 0);
    for (int k = 0; k < 8; k++) begin
      set_in(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), data_t'($urandom), 0);
      @(negedge clk);
      model_eval();
      checks++;
      if (w_obs !== e_vec) begin
        errors++;
        $display("FAIL pass status k=%0d got %b exp %b", k, w_obs, e_vec);
      end
      if (dl.valid_i) begin
        checks++;
        if (dl.valid_o !== 1'b1 || dl.d_o !== dl.d_i) begin
          errors++;
          $display("FAIL pass data k=%0d got %b/%h exp 1/%h", k, dl.valid_o, dl.d_o, dl.d_i);
        end
      end
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, 1'b1, 1'b0, 8'h00, (k == 0) ? MAX_DEPTH + 3 : MAX_DEPTH);
      @(negedge clk);
      model_eval();
      checks++;
      if (w_obs !== e_vec) begin
        errors++;
        $display("FAIL ovf status k=%0d got %b exp %b", k, w_obs, e_vec);
      end
      if (dl.depth_err_o) pulses++;
      tick();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL ovf err_pulses got %0d exp 1", pulses);
    end
    checks++;
    if (dl.depth_o !== DW'(MAX_DEPTH)) begin
      errors++;
      $display("FAIL ovf depth got %0d exp %0d", dl.depth_o, MAX_DEPTH);
    end
  endtask

  task automatic test_flush();
    int vcount = 0;
    idle(2, 4);
    for (int k = 0; k < 12; k++) begin
      set_in(k == 3, 1'b1, k <= 3, data_t'(8'hC0 + k), (k < 3) ? 4 : 6);
      @(negedge clk);
      model_eval();
      checks++;
      if (w_obs !== e_vec) begin
        errors++;
        $display("FAIL flush status k=%0d got %b exp %b", k, w_obs, e_vec);
      end
      if (k == 4) begin
        checks++;
        if (dl.cnt_o !== DW'(0) || dl.valid_o !== 1'b0 || dl.depth_o !== DW'(6)) begin
          errors++;
          $display("FAIL flush after cnt/valid/depth got %0d/%b/%0d exp 0/0/6", dl.cnt_o, dl.valid_o, dl.depth_o);
        end
      end
      if (dl.valid_o) vcount++;
      tick();
    end
    checks++;
    if (vcount != 0) begin
      errors++;
      $display("FAIL flush leaked got %0d exp 0", vcount);
    end
  endtask

  task automatic test_stale();
    int stale = 0;
    idle(2, 2);
    for (int k = 0; k < 20; k++) begin
      set_in(1'b0, 1'b1, k < 4, data_t'(8'h50 + k), (k < 8) ? 2 : MAX_DEPTH);
      @(negedge clk);
      model_eval();
      checks++;
      if (w_obs !== e_vec) begin
        errors++;
        $display("FAIL stale status k=%0d got %b exp %b", k, w_obs, e_vec);
      end
      if (e_dchk) begin
        checks++;
        if (dl.d_o !== e_d) begin
          errors++;
          $display("FAIL stale data k=%0d got %h exp %h", k, dl.d_o, e_d);
        end
      end
      if (k >= 9 && dl.valid_o) stale++;
      tick();
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL stale reappeared got %0d exp 0", stale);
    end
  endtask

  task automatic test_random();
    int dep = m_depth;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) dep = $urandom_range(0, MAX_DEPTH + 3);
      set_in($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
             data_t'($urandom), dep);
      @(negedge clk);
      model_eval();
      checks++;
      if (w_obs !== e_vec) begin
        errors++;
        $display("FAIL random status k=%0d got %b exp %b", k, w_obs, e_vec);
      end
      if (e_dchk) begin
        checks++;
        if (dl.d_o !== e_d) begin
          errors++;
          $display("FAIL random data k=%0d got %h exp %h", k, dl.d_o, e_d);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_depth_change();
    test_passthrough();
    test_flush();
    test_stale();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
